// File: rtl/damage_apply_pkg.sv
// Shared definitions for the damage stages: sizes, one-hot state
// encodings and the Done/Busy bit positions of the state vector.
package damage_apply_pkg;

    localparam int N_SLOTS = 16;
    localparam int HP_W    = 8;
    localparam int DMG_W   = 12;

    // One-hot handshake states, common to the summing and applying stages.
    typedef enum logic [2:0] {
        ST_INITIAL = 3'b001,
        ST_APPLY   = 3'b010,
        ST_DONE    = 3'b100
    } state_e;

    localparam int BUSY_BIT = 1;
    localparam int DONE_BIT = 2;

endpackage

// File: rtl/damage_apply_hp_slot_mux.sv
// 16:1 selector picking the HP of the slot currently being processed.
module hp_slot_mux
    import damage_apply_pkg::*;
(
    input  logic [N_SLOTS*HP_W-1:0] hp_i,
    input  logic [3:0]              sel_i,
    output logic [HP_W-1:0]         hp_o
);

    // Pure combinational slice of the flattened HP bank.
    always_comb begin
        hp_o = hp_i[sel_i*HP_W +: HP_W];
    end

endmodule

// File: rtl/damage_apply.sv
// Applies one frame's damage total to a bank of 16 HP slots, front to
// back, one slot per cycle, skipping dead slots and carrying overflow.
module damage_apply
    import damage_apply_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Ack,
    input  logic [DMG_W-1:0] Damage,
    input  logic             wrEn,
    input  logic [3:0]       wrIdx,
    input  logic [HP_W-1:0]  wrHp,
    output logic [HP_W-1:0]  hp0,
    output logic [HP_W-1:0]  hp1,
    output logic [HP_W-1:0]  hp2,
    output logic [HP_W-1:0]  hp3,
    output logic [HP_W-1:0]  hp4,
    output logic [HP_W-1:0]  hp5,
    output logic [HP_W-1:0]  hp6,
    output logic [HP_W-1:0]  hp7,
    output logic [HP_W-1:0]  hp8,
    output logic [HP_W-1:0]  hp9,
    output logic [HP_W-1:0]  hp10,
    output logic [HP_W-1:0]  hp11,
    output logic [HP_W-1:0]  hp12,
    output logic [HP_W-1:0]  hp13,
    output logic [HP_W-1:0]  hp14,
    output logic [HP_W-1:0]  hp15,
    output logic [15:0]      alive,
    output logic [4:0]       killed,
    output logic [DMG_W-1:0] remaining,
    output logic             Busy,
    output logic             Done
);

    state_e                           state_q, state_d;
    logic [N_SLOTS-1:0][HP_W-1:0]     hp_q, hp_d;
    logic [DMG_W-1:0]                 rem_q, rem_d;
    logic [3:0]                       idx_q, idx_d;
    logic [4:0]                       killed_q, killed_d;
    logic [HP_W-1:0]                  cur_hp;

    hp_slot_mux u_mux (
        .hp_i  (hp_q),
        .sel_i (idx_q),
        .hp_o  (cur_hp)
    );

    // State, HP bank, slot counter and damage bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_INITIAL;
            hp_q     <= '0;
            rem_q    <= '0;
            idx_q    <= '0;
            killed_q <= '0;
        end else begin
            state_q  <= state_d;
            hp_q     <= hp_d;
            rem_q    <= rem_d;
            idx_q    <= idx_d;
            killed_q <= killed_d;
        end
    end

    // Next-state: writes/Start in INITIAL, one slot per cycle in APPLY,
    // hold until Ack in DONE. Subtraction only under the >= guard, and the
    // else branch has rem < hp <= 255 so rem fits in HP_W there.
    always_comb begin
        state_d  = state_q;
        hp_d     = hp_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        killed_d = killed_q;
        case (state_q)
            ST_INITIAL: begin
                if (wrEn) hp_d[wrIdx] = wrHp;
                if (Start) begin
                    rem_d    = Damage;
                    idx_d    = '0;
                    killed_d = '0;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (cur_hp != '0) begin
                    if (rem_q >= DMG_W'(cur_hp)) begin
                        rem_d        = rem_q - DMG_W'(cur_hp);
                        hp_d[idx_q]  = '0;
                        killed_d     = killed_q + 5'd1;
                    end else begin
                        hp_d[idx_q]  = cur_hp - rem_q[HP_W-1:0];
                        rem_d        = '0;
                    end
                end
                if (rem_d == '0 || idx_q == 4'(N_SLOTS-1)) state_d = ST_DONE;
                else                                      idx_d   = idx_q + 4'd1;
            end
            ST_DONE: begin
                if (Ack) state_d = ST_INITIAL;
            end
            default: state_d = ST_INITIAL;
        endcase
    end

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_alive
        assign alive[i] = (hp_q[i] != '0);
    end

    assign hp0  = hp_q[0];
    assign hp1  = hp_q[1];
    assign hp2  = hp_q[2];
    assign hp3  = hp_q[3];
    assign hp4  = hp_q[4];
    assign hp5  = hp_q[5];
    assign hp6  = hp_q[6];
    assign hp7  = hp_q[7];
    assign hp8  = hp_q[8];
    assign hp9  = hp_q[9];
    assign hp10 = hp_q[10];
    assign hp11 = hp_q[11];
    assign hp12 = hp_q[12];
    assign hp13 = hp_q[13];
    assign hp14 = hp_q[14];
    assign hp15 = hp_q[15];

    assign killed    = killed_q;
    assign remaining = rem_q;
    assign Busy      = state_q[BUSY_BIT];
    assign Done      = state_q[DONE_BIT];

endmodule

// File: tb/tb_damage_apply.sv
// Bench for damage_apply: directed scenarios, a whole-application model
// and a per-cycle compare process.
module tb_damage_apply;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Start = 1'b0, Ack = 1'b0, wrEn = 1'b0;
    logic [11:0] Damage = '0;
    logic [3:0]  wrIdx = '0;
    logic [7:0]  wrHp = '0;
    logic [7:0]  h [16];
    logic [15:0] alive;
    logic [4:0]  killed;
    logic [11:0] remaining;
    logic        Busy, Done;

    damage_apply dut (
        .clk(clk), .rst(rst), .Start(Start), .Ack(Ack), .Damage(Damage),
        .wrEn(wrEn), .wrIdx(wrIdx), .wrHp(wrHp),
        .hp0(h[0]), .hp1(h[1]), .hp2(h[2]), .hp3(h[3]),
        .hp4(h[4]), .hp5(h[5]), .hp6(h[6]), .hp7(h[7]),
        .hp8(h[8]), .hp9(h[9]), .hp10(h[10]), .hp11(h[11]),
        .hp12(h[12]), .hp13(h[13]), .hp14(h[14]), .hp15(h[15]),
        .alive(alive), .killed(killed), .remaining(remaining),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: HP bank and the outcome of the last application.
    int m_hp [16];
    int m_killed = 0;
    int m_rem = 0;
    bit m_busy = 0, m_done = 0, m_valid = 0, m_rstchk = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Whole application in one go: spill damage front to back over live slots.
    function automatic int model_apply(input int dmg);
        int rem = dmg;
        int k = 0;
        int take;
        m_killed = 0;
        for (int i = 0; i < 16; i++) begin
            k = i + 1;
            if (m_hp[i] > 0) begin
                take = (rem < m_hp[i]) ? rem : m_hp[i];
                if (rem >= m_hp[i]) m_killed++;
                m_hp[i] -= take;
                rem     -= take;
            end
            if (rem == 0) break;
        end
        m_rem = rem;
        return k;
    endfunction

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            int exp_alive;
            chk("busy", Busy, m_busy);
            chk("done", Done, m_done);
            if (!m_busy) begin
                exp_alive = 0;
                for (int i = 0; i < 16; i++) begin
                    chk($sformatf("hp%0d", i), h[i], m_hp[i]);
                    if (m_hp[i] != 0) exp_alive |= (1 << i);
                end
                chk("alive", alive, exp_alive);
            end
            if (m_done || m_rstchk) begin
                chk("killed", killed, m_killed);
                chk("remaining", remaining, m_rem);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input int v);
        wrEn = 1'b1; wrIdx = 4'(i); wrHp = 8'(v);
        tick();
        wrEn = 1'b0;
        m_hp[i] = v;
    endtask

    // Accept Start (optionally with a same-cycle write); returns slots visited.
    task automatic start(input string name, input int dmg, input int exp_k,
                         input bit w, input int wi, input int wv, output int k);
        Start = 1'b1; Damage = 12'(dmg);
        if (w) begin wrEn = 1'b1; wrIdx = 4'(wi); wrHp = 8'(wv); end
        tick();
        Start = 1'b0; wrEn = 1'b0;
        if (w) m_hp[wi] = wv;
        k = model_apply(dmg);
        chk({name, "_k"}, k, exp_k);
        m_busy = 1; m_rstchk = 0;
    endtask

    task automatic finish(input int k);
        repeat (k - 1) tick();
        tick();
        m_busy = 0; m_done = 1;
    endtask

    task automatic ack;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        m_done = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 16; i++) m_hp[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        m_valid = 1; m_rstchk = 1;
        tick();

        // Spill across slots
        wr(0, 10); wr(1, 20); wr(2, 5);
        start("spill", 25, 2, 0, 0, 0, k);
        finish(k);
        chk("spill_hp1", h[1], 5);
        chk("spill_alive", alive, 16'h0006);
        chk("spill_killed", killed, 1);
        chk("spill_m_rem", m_rem, 0);
        ack();

        // Dead slots are skipped
        wr(1, 0); wr(2, 0); wr(3, 7);
        start("skip", 7, 4, 0, 0, 0, k);
        finish(k);
        chk("skip_hp3", h[3], 0);
        chk("skip_killed", killed, 1);
        ack();

        // Overkill wipes the bank and reports the excess
        for (int i = 0; i < 16; i++) wr(i, 100);
        start("overkill", 4095, 16, 0, 0, 0, k);
        chk("overkill_m_rem", m_rem, 2495);
        chk("overkill_m_killed", m_killed, 16);
        finish(k);
        chk("overkill_remaining", remaining, 2495);
        chk("overkill_killed", killed, 16);
        ack();

        // Reset mid-APPLY
        for (int i = 0; i < 16; i++) wr(i, 200);
        start("rstmid", 4095, 16, 0, 0, 0, k);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) m_hp[i] = 0;
        m_busy = 0; m_done = 0; m_killed = 0; m_rem = 0; m_rstchk = 1;
        chk("rstmid_alive", alive, 0);
        chk("rstmid_busy", Busy, 0);
        tick();

        // Zero damage; writes and Start outside INITIAL are ignored
        wr(0, 9);
        start("zero", 0, 1, 0, 0, 0, k);
        wrEn = 1'b1; wrIdx = 4'd0; wrHp = 8'd77;
        finish(k);
        wrEn = 1'b1; wrIdx = 4'd1; wrHp = 8'd33;
        Start = 1'b1; Damage = 12'd5;
        tick();
        wrEn = 1'b0; Start = 1'b0;
        chk("zero_hp0", h[0], 9);
        chk("zero_hp1", h[1], 0);
        chk("zero_done_held", Done, 1);
        ack();
        tick();
        chk("zero_no_queued_start", Busy, 0);

        // Same-cycle write and Start
        start("samecyc", 30, 1, 1, 0, 50, k);
        finish(k);
        chk("samecyc_hp0", h[0], 20);
        chk("samecyc_killed", killed, 0);
        ack();
        tick();

        m_valid = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/damage_apply.md
# damage_apply

Applies a frame's total damage figure, as produced by the damage-sum stage, to one side's bank of 16 hit-point registers. Damage spills front to back: slot 0 first, dead slots skipped, overflow carried to the next living slot. It uses the same Start/Done/Ack handshake as the summing stage. Two instances are used, one per side, each fed the opposing side's total.

## Interface
- N_SLOTS, 16: number of HP slots; fixed, indexed by a 4-bit counter.
- HP_W, 8: HP register width.
- DMG_W, 12: damage and leftover width.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- Start  in  1  begin applying Damage; sampled only in INITIAL
- Ack  in  1  release from DONE; sampled only in DONE
- Damage  in  DMG_W  total damage; latched when Start is accepted
- wrEn  in  1  spawn/heal write strobe; honoured only in INITIAL
- wrIdx  in  4  slot to write
- wrHp  in  HP_W  value written to slot wrIdx
- hp0 … hp15  out  HP_W  current HP per slot (registered)
- alive  out  16  alive[i] = (hp_i != 0), combinational
- killed  out  5  slots taken from nonzero to 0 in the last application
- remaining  out  DMG_W  unspent damage after the last application (overkill)
- Busy  out  1  state == APPLY
- Done  out  1  state == DONE

## Operation
- States are one-hot: INITIAL = 3'b001, APPLY = 3'b010, DONE = 3'b100.
- Done = state[2] and Busy = state[1].
- Illegal state: go to INITIAL.
- INITIAL:
  - wrEn writes hp[wrIdx] <= wrHp.
  - On Start: rem <= Damage, I <= 0, killed <= 0, go to APPLY.
  - A write and Start in the same cycle are both taken; APPLY sees the written value.
- APPLY: one slot per cycle, slot I.
  - hp[I] == 0: no change.
  - rem >= hp[I] (hp zero-extended to DMG_W): rem <= rem − hp[I], hp[I] <= 0, killed <= killed + 1.
  - otherwise: hp[I] <= hp[I] − rem, rem <= 0.
  - Go to DONE when the next rem is 0 or I == 15; else I <= I + 1.
- DONE:
  - hp, killed and remaining (= rem) are held.
  - Ack: go to INITIAL.
- Start outside INITIAL, Ack outside DONE, and wrEn outside INITIAL are ignored. These are not queued.
- Damage = 0: one APPLY cycle, no HP change, killed = 0, remaining = 0.
- All arithmetic is unsigned. No underflow is possible, because subtraction happens only under the >= guard. killed saturates naturally at 16 (5 bits).

## Timing
- Reset values:
  - state INITIAL
  - all hp 0, alive 0
  - killed 0, remaining 0
  - Busy 0, Done 0
  - I 0
- Reset in any state (including mid-APPLY) aborts and clears all of the above on that edge.
- Latency: Start sampled at edge t0 → APPLY during cycles t0+1 … t0+k, where k = number of slots visited (1..16). Done is high from edge t0+k onward.
- Done stays high until the edge that samples Ack.
- INITIAL is re-entered on the edge after Ack is sampled. Start may be accepted on the following edge.
- hp outputs update on the same edge that processes the slot.
- remaining is valid whenever Done = 1.

## Structure
- Shared package holds:
  - state encodings INITIAL/APPLY/DONE
  - N_SLOTS, HP_W, DMG_W
  - the one-hot Done/Busy bit positions, shared with the damage-sum stage
- One natural sub-module: hp_slot_mux, a combinational 16:1 HP_W-bit selector driven by I. It feeds the compare/subtract datapath.
- HP registers, counter and FSM stay in damage_apply.

## Test plan
- Reset: assert rst mid-APPLY → next cycle all hp = 0, alive = 0, killed = 0, remaining = 0, Done = 0, Busy = 0.
- Spill: write hp0=10, hp1=20, hp2=5; Start, Damage=25 → after 2 APPLY cycles Done=1; hp0=0, hp1=5, hp2=5, killed=1, remaining=0, alive=16'h0006.
- Skip dead slots: only hp3=7; Damage=7 → 4 APPLY cycles; hp3=0, killed=1, remaining=0.
- Overkill: all hp=100; Damage=4095 → 16 APPLY cycles; all hp=0, killed=16, remaining=2495.
- Zero damage plus ignored inputs: hp0=9; Damage=0 → 1 APPLY cycle, hp0=9, killed=0.
  - wrEn during APPLY/DONE leaves hp unchanged.
  - Start in DONE is ignored.
  - Ack → INITIAL on the next edge.
- Same-cycle write and Start: wrEn hp0=50 with Start, Damage=30 → hp0=20, killed=0, Done after 1 APPLY cycle.
